// File: rtl/rob_ring_pkg.sv
// Shared constants and helpers for the reorder-buffer ring.
// The default depth and index width come from ROB_NUM / ROB_SEL. They are
// only defaults: the block itself is sized by its parameters.
`ifndef ROB_NUM
`define ROB_NUM 16
`endif
`ifndef ROB_SEL
`define ROB_SEL 4
`endif

package rob_ring_pkg;

  localparam int ROB_DEPTH_DEF = `ROB_NUM;
  localparam int ROB_IDX_DEF   = `ROB_SEL;

  // Number of set bits; lane masks are zero-extended into the argument.
  function automatic int popcnt(input logic [31:0] v);
    int n;
    n = 0;
    for (int b = 0; b < 32; b++) begin
      n += int'(v[b]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rob_ring_if.sv
// Dispatch / completion / commit / flush bundle of the reorder-buffer ring.
interface rob_ring_if
  import rob_ring_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH_DEF,
  parameter int DISP_W = 2,
  parameter int CMT_W  = 2,
  parameter int CPL_W  = 2,
  parameter int PAY_W  = 32
) ();
  localparam int IDX_W = $clog2(DEPTH);

  logic [DISP_W-1:0]       disp_valid;
  logic [DISP_W*PAY_W-1:0] disp_payload;
  logic                    disp_ready;
  logic [DISP_W*IDX_W-1:0] disp_idx;
  logic [CPL_W-1:0]        cpl_valid;
  logic [CPL_W*IDX_W-1:0]  cpl_idx;
  logic                    commit_en;
  logic [CMT_W-1:0]        cmt_valid;
  logic [CMT_W*IDX_W-1:0]  cmt_idx;
  logic [CMT_W*PAY_W-1:0]  cmt_payload;
  logic                    flush_valid;
  logic [IDX_W-1:0]        flush_idx;
  logic                    flush_all;
  logic [IDX_W:0]          count;
  logic                    full;
  logic                    empty;

  modport master (
    output disp_valid, disp_payload, cpl_valid, cpl_idx, commit_en,
           flush_valid, flush_idx, flush_all,
    input  disp_ready, disp_idx, cmt_valid, cmt_idx, cmt_payload,
           count, full, empty
  );

  modport slave (
    input  disp_valid, disp_payload, cpl_valid, cpl_idx, commit_en,
           flush_valid, flush_idx, flush_all,
    output disp_ready, disp_idx, cmt_valid, cmt_idx, cmt_payload,
           count, full, empty
  );
endinterface

// File: rtl/rob_ring_commit_scan.sv
// Contiguous ready-prefix scan over the commit window starting at head.
module rob_commit_scan #(
  parameter int CMT_W = 2
) (
  input  logic             en_i,
  input  logic [CMT_W-1:0] win_i,
  output logic [CMT_W-1:0] mask_o
);
  // Lane k retires only if every older lane in the window also retires.
  always_comb begin
    logic run;
    mask_o = '0;
    run    = en_i;
    for (int k = 0; k < CMT_W; k++) begin
      run       = run & win_i[k];
      mask_o[k] = run;
    end
  end
endmodule

// File: rtl/rob_ring.sv
// Reorder-buffer ring: in-order allocate, out-of-order complete, in-order
// retire, with partial and full squash.
module rob_ring
  import rob_ring_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH_DEF,
  parameter int DISP_W = 2,
  parameter int CMT_W  = 2,
  parameter int CPL_W  = 2,
  parameter int PAY_W  = 32
) (
  input logic       clk,
  input logic       reset,
  rob_ring_if.slave rob
);
  localparam int IDX_W = $clog2(DEPTH);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4) begin : g_bad_depth
    $error("rob_ring: DEPTH must be a power of two and at least 4");
  end
  if (DEPTH == ROB_DEPTH_DEF && IDX_W != ROB_IDX_DEF) begin : g_bad_sel
    $error("rob_ring: ROB_SEL does not match ROB_NUM");
  end

  logic [IDX_W:0]   head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [PAY_W-1:0] pay_q [DEPTH];

  logic [IDX_W:0]         count_w;
  logic [IDX_W-1:0]       head_lo, tail_lo, flush_off;
  logic                   disp_ready_w, disp_fire, flush_part;
  logic [CMT_W-1:0]       win, cmt_mask;
  logic [CMT_W*IDX_W-1:0] cmt_idx_w;
  logic [CMT_W*PAY_W-1:0] cmt_pay_w;
  logic [DISP_W*IDX_W-1:0] disp_idx_w;

  assign head_lo      = head_q[IDX_W-1:0];
  assign tail_lo      = tail_q[IDX_W-1:0];
  assign count_w      = tail_q - head_q;
  assign disp_ready_w = (int'(count_w) + DISP_W) <= DEPTH;
  // A squash point that is not a live entry is simply not a flush.
  assign flush_part   = rob.flush_valid && !rob.flush_all && valid_q[rob.flush_idx];
  assign flush_off    = rob.flush_idx - head_lo;
  assign disp_fire    = disp_ready_w && !flush_part;

  // Commit window and allocation indices, lane 0 = oldest / first.
  for (genvar gi = 0; gi < CMT_W; gi++) begin : g_win
    logic [IDX_W-1:0] slot;
    assign slot    = head_lo + IDX_W'(gi);
    // Entries being squashed this cycle must not retire alongside the flush.
    assign win[gi] = valid_q[slot] & done_q[slot] &
                     (!flush_part || (IDX_W'(gi) <= flush_off));
    assign cmt_idx_w[gi*IDX_W +: IDX_W] = slot;
    assign cmt_pay_w[gi*PAY_W +: PAY_W] = pay_q[slot];
  end

  for (genvar gi = 0; gi < DISP_W; gi++) begin : g_disp
    assign disp_idx_w[gi*IDX_W +: IDX_W] = tail_lo + IDX_W'(gi);
  end

  rob_commit_scan #(.CMT_W(CMT_W)) u_scan (
    .en_i   (rob.commit_en && !rob.flush_all),
    .win_i  (win),
    .mask_o (cmt_mask)
  );

  assign rob.cmt_valid   = cmt_mask;
  assign rob.cmt_idx     = cmt_idx_w;
  assign rob.cmt_payload = cmt_pay_w;
  assign rob.disp_idx    = disp_idx_w;
  assign rob.disp_ready  = disp_ready_w;
  assign rob.count       = count_w;
  assign rob.full        = (int'(count_w) == DEPTH);
  assign rob.empty       = (count_w == '0);

  // Next-state of pointers and status bits: complete, retire, squash or
  // allocate, with flush_all overriding everything.
  always_comb begin
    logic [IDX_W-1:0] ci;
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ci      = '0;

    for (int p = 0; p < CPL_W; p++) begin
      ci = rob.cpl_idx[p*IDX_W +: IDX_W];
      if (rob.cpl_valid[p] && valid_q[ci]) begin
        done_d[ci] = 1'b1;
      end
    end

    for (int k = 0; k < CMT_W; k++) begin
      if (cmt_mask[k]) begin
        valid_d[head_lo + IDX_W'(k)] = 1'b0;
        done_d[head_lo + IDX_W'(k)]  = 1'b0;
      end
    end
    head_d = head_q + (IDX_W+1)'(popcnt(32'(cmt_mask)));

    if (flush_part) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (IDX_W'(IDX_W'(i) - head_lo) > flush_off) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      tail_d = head_q + (IDX_W+1)'(flush_off) + (IDX_W+1)'(1);
    end else if (disp_fire) begin
      for (int l = 0; l < DISP_W; l++) begin
        if (rob.disp_valid[l]) begin
          valid_d[tail_lo + IDX_W'(l)] = 1'b1;
          done_d[tail_lo + IDX_W'(l)]  = 1'b0;
        end
      end
      tail_d = tail_q + (IDX_W+1)'(popcnt(32'(rob.disp_valid)));
    end

    if (rob.flush_all) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload storage, written on allocation only; never needs clearing.
  always_ff @(posedge clk) begin
    if (disp_fire && !rob.flush_all) begin
      for (int l = 0; l < DISP_W; l++) begin
        if (rob.disp_valid[l]) begin
          pay_q[tail_lo + IDX_W'(l)] <= rob.disp_payload[l*PAY_W +: PAY_W];
        end
      end
    end
  end
endmodule

// File: tb/tb_rob_ring.sv
// Scenario bench for rob_ring at DEPTH=8 with two lanes everywhere.
module tb_rob_ring;
  localparam int DEPTH = 8, DISP_W = 2, CMT_W = 2, CPL_W = 2, PAY_W = 32;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [PAY_W-1:0] pay;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  ent_t sb[$];
  logic [PAY_W-1:0] next_pay = 32'hA000_0000;

  rob_ring_if #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CMT_W(CMT_W), .CPL_W(CPL_W), .PAY_W(PAY_W)) rif ();

  rob_ring #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CMT_W(CMT_W), .CPL_W(CPL_W), .PAY_W(PAY_W)) dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Retirement monitor: every retiring lane must match the oldest expected entry.
  always begin
    @(negedge clk);
    #2;
    if (reset !== 1'b1) begin
      for (int k = 0; k < CMT_W; k++) begin
        if (rif.cmt_valid[k] === 1'b1) begin
          ent_t e;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected lane=%0d idx=%0d (no entry expected)", k, rif.cmt_idx[k*IDX_W +: IDX_W]);
          end else begin
            e = sb.pop_front();
            if (rif.cmt_idx[k*IDX_W +: IDX_W] !== e.idx || rif.cmt_payload[k*PAY_W +: PAY_W] !== e.pay) begin
              errors++;
              $display("FAIL commit_data lane=%0d got idx=%0d pay=%h want idx=%0d pay=%h", k,
                       rif.cmt_idx[k*IDX_W +: IDX_W], rif.cmt_payload[k*PAY_W +: PAY_W], e.idx, e.pay);
            end else begin
              $display("commit lane=%0d idx=%0d pay=%h", k, e.idx, e.pay);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rif.disp_valid   = '0;
    rif.disp_payload = '0;
    rif.cpl_valid    = '0;
    rif.cpl_idx      = '0;
    rif.commit_en    = 1'b0;
    rif.flush_valid  = 1'b0;
    rif.flush_idx    = '0;
    rif.flush_all    = 1'b0;
  endtask

  // Allocate two entries expected at exp0, exp0+1 and record them.
  task automatic disp_pair(input int exp0);
    logic [IDX_W-1:0] i0, i1;
    ent_t e0, e1;
    i0 = IDX_W'(exp0);
    i1 = IDX_W'(exp0 + 1);
    rif.disp_valid   = 2'b11;
    rif.disp_payload = {next_pay + 32'd1, next_pay};
    #1;
    checks++;
    if (rif.disp_ready !== 1'b1 || rif.disp_idx !== {i1, i0}) begin
      errors++;
      $display("FAIL disp_pair got ready=%b idx=%h want ready=1 idx=%h", rif.disp_ready, rif.disp_idx, {i1, i0});
    end else begin
      $display("dispatch idx=%0d,%0d", i0, i1);
    end
    e0.idx = i0; e0.pay = next_pay;
    e1.idx = i1; e1.pay = next_pay + 32'd1;
    sb.push_back(e0);
    sb.push_back(e1);
    next_pay = next_pay + 32'd2;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (rif.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", rif.count); end
    checks++; if (rif.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", rif.empty); end
    checks++; if (rif.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", rif.full); end
    checks++; if (rif.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", rif.disp_ready); end
    checks++; if (rif.cmt_valid !== 2'b00) begin errors++; $display("FAIL reset_cmt got=%b want=00", rif.cmt_valid); end
    $display("reset done");
  endtask

  task automatic test_fill();
    for (int c = 0; c < 4; c++) disp_pair(2 * c);
    checks++; if (rif.full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b want=1", rif.full); end
    checks++; if (rif.disp_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got=%b want=0", rif.disp_ready); end
    checks++; if (rif.count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d want=8", rif.count); end
    rif.disp_valid   = 2'b11;
    rif.disp_payload = {32'hDEAD_0001, 32'hDEAD_0000};
    tick();
    idle();
    checks++; if (rif.count !== 4'd8) begin errors++; $display("FAIL full_ignore_count got=%0d want=8", rif.count); end
    checks++; if (rif.disp_idx !== {3'd1, 3'd0}) begin errors++; $display("FAIL full_ignore_idx got=%h want=%h", rif.disp_idx, {3'd1, 3'd0}); end
    $display("fill done count=%0d", rif.count);
  endtask

  task automatic test_commit_order();
    rif.commit_en = 1'b1;
    rif.cpl_valid = 2'b01;
    rif.cpl_idx   = {3'd0, 3'd1};
    #1;
    checks++; if (rif.cmt_valid !== 2'b00) begin errors++; $display("FAIL order_c0 got=%b want=00", rif.cmt_valid); end
    tick();
    rif.commit_en = 1'b1;
    rif.cpl_valid = 2'b01;
    rif.cpl_idx   = {3'd0, 3'd0};
    #1;
    checks++; if (rif.cmt_valid !== 2'b00) begin errors++; $display("FAIL order_c1 got=%b want=00", rif.cmt_valid); end
    tick();
    rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.cmt_valid !== 2'b11 || rif.cmt_idx !== {3'd1, 3'd0}) begin
      errors++; $display("FAIL order_c2 got valid=%b idx=%h want valid=11 idx=%h", rif.cmt_valid, rif.cmt_idx, {3'd1, 3'd0});
    end
    tick();
    idle();
    checks++; if (rif.count !== 4'd6) begin errors++; $display("FAIL order_count got=%0d want=6", rif.count); end
  endtask

  task automatic test_wrap();
    rif.cpl_valid = 2'b11; rif.cpl_idx = {3'd2, 3'd2}; tick();
    rif.cpl_valid = 2'b11; rif.cpl_idx = {3'd4, 3'd3}; tick();
    rif.cpl_valid = 2'b11; rif.cpl_idx = {3'd2, 3'd5}; tick();
    idle();
    rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.cmt_valid !== 2'b11 || rif.cmt_idx !== {3'd3, 3'd2}) begin
      errors++; $display("FAIL wrap_r23 got valid=%b idx=%h", rif.cmt_valid, rif.cmt_idx);
    end
    tick();
    rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.cmt_valid !== 2'b11 || rif.count !== 4'd4) begin
      errors++; $display("FAIL wrap_r45 got valid=%b count=%0d want valid=11 count=4", rif.cmt_valid, rif.count);
    end
    tick();
    idle();
    checks++; if (rif.count !== 4'd2) begin errors++; $display("FAIL wrap_count2 got=%0d want=2", rif.count); end
    disp_pair(0);
    checks++; if (rif.count !== 4'd4) begin errors++; $display("FAIL wrap_count4 got=%0d want=4", rif.count); end
    rif.commit_en = 1'b1; rif.cpl_valid = 2'b11; rif.cpl_idx = {3'd7, 3'd6};
    #1;
    checks++; if (rif.cmt_valid !== 2'b00) begin errors++; $display("FAIL wrap_same_cycle got=%b want=00", rif.cmt_valid); end
    tick();
    rif.commit_en = 1'b1; rif.cpl_valid = 2'b01; rif.cpl_idx = {3'd0, 3'd0};
    #1;
    checks++; if (rif.cmt_valid !== 2'b11 || rif.cmt_idx !== {3'd7, 3'd6}) begin
      errors++; $display("FAIL wrap_r67 got valid=%b idx=%h", rif.cmt_valid, rif.cmt_idx);
    end
    tick();
    rif.commit_en = 1'b1; rif.cpl_valid = 2'b00;
    #1;
    checks++; if (rif.cmt_valid !== 2'b01 || rif.cmt_idx[2:0] !== 3'd0 || rif.count !== 4'd2) begin
      errors++; $display("FAIL wrap_r0 got valid=%b idx0=%0d count=%0d want 01/0/2", rif.cmt_valid, rif.cmt_idx[2:0], rif.count);
    end
    tick();
    rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.cmt_valid !== 2'b00 || rif.count !== 4'd1) begin
      errors++; $display("FAIL wrap_stall got valid=%b count=%0d want 00/1", rif.cmt_valid, rif.count);
    end
    rif.cpl_valid = 2'b10; rif.cpl_idx = {3'd1, 3'd0};
    tick();
    rif.cpl_valid = 2'b00; rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.cmt_valid !== 2'b01 || rif.cmt_idx[2:0] !== 3'd1) begin
      errors++; $display("FAIL wrap_r1 got valid=%b idx0=%0d want 01/1", rif.cmt_valid, rif.cmt_idx[2:0]);
    end
    tick();
    idle();
    checks++; if (rif.empty !== 1'b1 || rif.count !== 4'd0) begin
      errors++; $display("FAIL wrap_empty got empty=%b count=%0d want 1/0", rif.empty, rif.count);
    end
  endtask

  task automatic test_flush_partial();
    disp_pair(2); disp_pair(4); disp_pair(6);
    checks++; if (rif.count !== 4'd6) begin errors++; $display("FAIL flush_pre_count got=%0d want=6", rif.count); end
    rif.flush_valid = 1'b1; rif.flush_idx = 3'd4;
    rif.disp_valid = 2'b11; rif.disp_payload = {32'hBAD0_0001, 32'hBAD0_0000};
    tick();
    idle();
    for (int n = 0; n < 3; n++) void'(sb.pop_back());
    checks++; if (rif.count !== 4'd3) begin errors++; $display("FAIL flush_count got=%0d want=3", rif.count); end
    disp_pair(5);
    checks++; if (rif.count !== 4'd5) begin errors++; $display("FAIL flush_redisp_count got=%0d want=5", rif.count); end
    rif.flush_valid = 1'b1; rif.flush_idx = 3'd0;
    tick();
    idle();
    checks++; if (rif.count !== 4'd5 || rif.disp_idx !== {3'd0, 3'd7}) begin
      errors++; $display("FAIL flush_invalid got count=%0d idx=%h want 5/%h", rif.count, rif.disp_idx, {3'd0, 3'd7});
    end
    $display("partial flush done count=%0d", rif.count);
  endtask

  task automatic test_flush_all();
    rif.cpl_valid = 2'b01; rif.cpl_idx = {3'd0, 3'd2};
    tick();
    idle();
    rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.cmt_valid !== 2'b01) begin errors++; $display("FAIL fa_pre_commit got=%b want=01", rif.cmt_valid); end
    tick();
    idle();
    disp_pair(7); disp_pair(1);
    checks++; if (rif.full !== 1'b1 || rif.count !== 4'd8) begin
      errors++; $display("FAIL fa_full got full=%b count=%0d want 1/8", rif.full, rif.count);
    end
    rif.cpl_valid = 2'b01; rif.cpl_idx = {3'd0, 3'd3};
    tick();
    rif.flush_all = 1'b1; rif.commit_en = 1'b1; rif.disp_valid = 2'b11;
    rif.cpl_valid = 2'b11; rif.cpl_idx = {3'd5, 3'd4};
    #1;
    checks++; if (rif.cmt_valid !== 2'b00) begin errors++; $display("FAIL fa_masked got=%b want=00", rif.cmt_valid); end
    tick();
    idle();
    sb.delete();
    rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.empty !== 1'b1 || rif.count !== 4'd0 || rif.cmt_valid !== 2'b00) begin
      errors++; $display("FAIL fa_after got empty=%b count=%0d cmt=%b want 1/0/00", rif.empty, rif.count, rif.cmt_valid);
    end
    rif.commit_en = 1'b0;
    disp_pair(0);
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    rif.cpl_valid = 2'b11; rif.cpl_idx = {3'd1, 3'd0};
    rif.disp_valid = 2'b11; rif.commit_en = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    sb.delete();
    rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.count !== 4'd0 || rif.empty !== 1'b1 || rif.full !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state got count=%0d empty=%b full=%b want 0/1/0", rif.count, rif.empty, rif.full);
    end
    checks++; if (rif.disp_ready !== 1'b1 || rif.cmt_valid !== 2'b00 || rif.disp_idx !== {3'd1, 3'd0}) begin
      errors++; $display("FAIL mid_reset_out got ready=%b cmt=%b idx=%h", rif.disp_ready, rif.cmt_valid, rif.disp_idx);
    end
    rif.commit_en = 1'b0;
    disp_pair(0);
    rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.cmt_valid !== 2'b00) begin errors++; $display("FAIL mid_not_done got=%b want=00", rif.cmt_valid); end
    rif.cpl_valid = 2'b11; rif.cpl_idx = {3'd1, 3'd0};
    tick();
    rif.cpl_valid = 2'b00; rif.commit_en = 1'b1;
    #1;
    checks++; if (rif.cmt_valid !== 2'b11) begin errors++; $display("FAIL mid_commit got=%b want=11", rif.cmt_valid); end
    tick();
    idle();
    checks++; if (rif.count !== 4'd0 || sb.size() != 0) begin
      errors++; $display("FAIL mid_drain got count=%0d pending=%0d want 0/0", rif.count, sb.size());
    end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_fill();
    test_commit_order();
    test_wrap();
    test_flush_partial();
    test_flush_all();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rob_ring.md
ROB_RING -- requirements
Module: rob_ring

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of two, >= 4).
REQ-002 SHALL have parameter DISP_W, default 2, dispatch lanes per cycle.
REQ-003 SHALL have parameter CMT_W, default 2, commit lanes per cycle.
REQ-004 SHALL have parameter CPL_W, default 2, completion ports.
REQ-005 SHALL have parameter PAY_W, default 32, per-entry payload width; IDX_W = log2(DEPTH).
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 disp_valid  in  DISP_W  per-lane allocate request; lanes contiguous from lane 0.
REQ-009 disp_payload  in  DISP_W*PAY_W  per-lane payload.
REQ-010 disp_ready  out  1  high when free entries >= DISP_W.
REQ-011 disp_idx  out  DISP_W*IDX_W  index lane i receives: tail+i mod DEPTH.
REQ-012 cpl_valid  in  CPL_W  per-port completion strobe.
REQ-013 cpl_idx  in  CPL_W*IDX_W  entry marked done.
REQ-014 commit_en  in  1  permits retirement this cycle.
REQ-015 cmt_valid  out  CMT_W  lanes retiring this cycle, contiguous from lane 0.
REQ-016 cmt_idx / cmt_payload  out  CMT_W*IDX_W / CMT_W*PAY_W  retiring entries, oldest in lane 0.
REQ-017 flush_valid  in  1  partial squash: discard entries younger than flush_idx.
REQ-018 flush_idx  in  IDX_W  youngest surviving entry.
REQ-019 flush_all  in  1  discard all entries.
REQ-020 count  out  IDX_W+1  occupied entries; full, empty  out  1  count==DEPTH / count==0.

Function
REQ-021 Head/tail SHALL be IDX_W+1 bits (wrap bit); count = tail-head; full/empty derived from pointers, combinational from registers.
REQ-022 Dispatch SHALL occur only when disp_ready; lane i with disp_valid writes payload, valid=1, done=0 at tail+i; tail advances by popcount(disp_valid).
REQ-023 disp_valid while !disp_ready SHALL be ignored with no state change.
REQ-024 Completion SHALL set done at cpl_idx on the next edge; completion to an invalid entry SHALL be ignored; duplicate ports to same index SHALL be harmless.
REQ-025 cmt_valid[k] SHALL be combinational: commit_en && entries head..head+k all valid && done; retirement stops at the first not-done entry.
REQ-026 Retired entries SHALL clear valid/done and head SHALL advance by popcount(cmt_valid) on the same edge.
REQ-027 Completion in cycle N SHALL be visible to commit no earlier than cycle N+1.
REQ-028 flush_all SHALL clear all valid bits, head=tail=0, overriding dispatch, completion and commit that cycle.
REQ-029 flush_valid (no flush_all) SHALL set tail=flush_idx+1 with correct wrap bit and clear valid of squashed entries; dispatch that cycle SHALL be dropped; commit that cycle SHALL proceed.
REQ-030 flush_valid with flush_idx not a valid entry SHALL be ignored.
REQ-031 Dispatch and commit in the same cycle SHALL both take effect; count changes by dispatched-retired; full-buffer dispatch uses start-of-cycle count.
REQ-032 Pointer wrap past DEPTH-1 SHALL be seamless for dispatch, commit and flush.

Reset
REQ-033 On reset: head=tail=0, all valid/done=0, count=0, empty=1, full=0, disp_ready=1, cmt_valid=0; payload storage need not reset.
REQ-034 Reset SHALL override all inputs that cycle; mid-operation reset discards all entries.

Structure
REQ-035 DEPTH/IDX_W defaults SHALL live in constants.vh (`ROB_NUM, `ROB_SEL); block SHALL be parameter-driven, not macro-bound.
REQ-036 Contiguous-done prefix scan from head SHALL be sub-module rob_commit_scan (inputs: rotated valid&done window of CMT_W; output: cmt_valid mask).

Verification (DEPTH=8, DISP_W=2, CMT_W=2, CPL_W=2)
REQ-037 Reset, dispatch 2/cycle for 4 cycles -> disp_idx 0/1,2/3,4/5,6/7; full=1, disp_ready=0, count=8.
REQ-038 Complete idx 1 then idx 0, commit_en=1 -> no retire until idx 0 done; next cycle cmt_valid=2'b11, idx 0,1.
REQ-039 Wrap: retire 0-5, dispatch 2 -> disp_idx 0,1; retire 6,7,0 in order; count correct throughout.
REQ-040 Entries 2-7 live, flush_valid idx=4 -> tail=5, count=3, same-cycle dispatch dropped; next disp_idx 5,6.
REQ-041 Full buffer, flush_all with commit/dispatch pending -> empty=1, count=0, cmt_valid=0; next dispatch idx 0.
REQ-042 Reset asserted mid-stream with cpl_valid and disp_valid high -> next cycle matches reset values.
